ascon_perm_ctrl: RTL

//  Iterative sequencer around one combinational ascon_p round instance.

---
 rtl/ascon_perm_ctrl_pkg.sv | 32 +++
 rtl/ascon_perm_ctrl_p.sv | 47 ++++
 rtl/ascon_perm_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/ascon_perm_ctrl_pkg.sv
// Ascon permutation controller: shared constants, types and helpers.
// Round constant generator and 64-bit rotate used by the round datapath.
package ascon_perm_ctrl_pkg;

  localparam int ASCON_ROUNDS_MAX = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fsm_t;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  function automatic logic [7:0] ascon_rc(input logic [3:0] idx);
    return {4'hF - idx, idx};
  endfunction

  function automatic logic [63:0] ror64(
    input logic [63:0] v,
    input int unsigned r
  );
    return (v >> r) | (v << (64 - r));
  endfunction

endpackage

// File: rtl/ascon_perm_ctrl_p.sv
// One combinational Ascon round: constant add, bitsliced S-box, linear layer.
// The 8-bit round constant lands in the low byte of x2 only.
module ascon_perm_ctrl_p
  import ascon_perm_ctrl_pkg::*;
(
  input  ascon_state_t s,
  input  logic [7:0]   rc,
  output ascon_state_t q
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;

  assign a0 = s.x0 ^ s.x4;
  assign a1 = s.x1;
  assign a2 = s.x2 ^ {56'd0, rc} ^ s.x1;
  assign a3 = s.x3;
  assign a4 = s.x4 ^ s.x3;

  assign t0 = ~a0 & a1;
  assign t1 = ~a1 & a2;
  assign t2 = ~a2 & a3;
  assign t3 = ~a3 & a4;
  assign t4 = ~a4 & a0;

  assign b0 = a0 ^ t1;
  assign b1 = a1 ^ t2;
  assign b2 = a2 ^ t3;
  assign b3 = a3 ^ t4;
  assign b4 = a4 ^ t0;

  // Output mixing uses the pre-update b0/b2 values
  assign c1 = b1 ^ b0;
  assign c0 = b0 ^ b4;
  assign c3 = b3 ^ b2;
  assign c2 = ~b2;
  assign c4 = b4;

  assign q.x0 = c0 ^ ror64(c0, 19) ^ ror64(c0, 28);
  assign q.x1 = c1 ^ ror64(c1, 61) ^ ror64(c1, 39);
  assign q.x2 = c2 ^ ror64(c2, 1)  ^ ror64(c2, 6);
  assign q.x3 = c3 ^ ror64(c3, 10) ^ ror64(c3, 17);
  assign q.x4 = c4 ^ ror64(c4, 7)  ^ ror64(c4, 41);

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Iterative p^a / p^b sequencer: one Ascon round per clock around a single
// round instance, with valid/ready handshakes on both sides.
module ascon_perm_ctrl
  import ascon_perm_ctrl_pkg::*;
#(
  parameter int PA_ROUNDS = 12,
  parameter int PB_ROUNDS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [63:0] x0_in,
  input  logic [63:0] x1_in,
  input  logic [63:0] x2_in,
  input  logic [63:0] x3_in,
  input  logic [63:0] x4_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] x0_out,
  output logic [63:0] x1_out,
  output logic [63:0] x2_out,
  output logic [63:0] x3_out,
  output logic [63:0] x4_out,
  output logic        busy
);

  if (PA_ROUNDS < 1 || PA_ROUNDS > ASCON_ROUNDS_MAX) begin : g_bad_pa
    $error("PA_ROUNDS must be in 1..12");
  end
  if (PB_ROUNDS < 1 || PB_ROUNDS > ASCON_ROUNDS_MAX) begin : g_bad_pb
    $error("PB_ROUNDS must be in 1..12");
  end

  // Rounds always end at idx 11, so a shorter job starts further in
  localparam logic [3:0] IDX_A = 4'(ASCON_ROUNDS_MAX - PA_ROUNDS);
  localparam logic [3:0] IDX_B = 4'(ASCON_ROUNDS_MAX - PB_ROUNDS);

  fsm_t         fsm;
  ascon_state_t st;
  ascon_state_t nxt;
  logic [3:0]   idx;
  logic [7:0]   rc;

  assign rc = ascon_rc(idx);

  ascon_perm_ctrl_p u_ascon_p (
    .s  (st),
    .rc (rc),
    .q  (nxt)
  );

  assign x0_out = st.x0;
  assign x1_out = st.x1;
  assign x2_out = st.x2;
  assign x3_out = st.x3;
  assign x4_out = st.x4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= ST_IDLE;
      st        <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (fsm)
        ST_IDLE: begin
          if (in_valid) begin
            st       <= {x0_in, x1_in, x2_in, x3_in, x4_in};
            idx      <= in_mode ? IDX_B : IDX_A;
            fsm      <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          st <= nxt;
          if (idx == 4'd11) begin
            fsm       <= ST_DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            fsm       <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule
